// File: rtl/text_console.sv
// Character-stream console: turns an ASCII byte stream into video-memory writes
// over a COLS x ROWS text grid, with burst clears for new rows and form feed.
module text_console #(
    parameter int unsigned COLS  = 50,
    parameter int unsigned ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        CLK_CPU,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        video_write_enable,
    output logic [7:0]  video_write_data,
    output logic [10:0] video_write_addr,
    output logic [4:0]  cursor_row,
    output logic [5:0]  cursor_col
);
    localparam logic [10:0] COLS_W   = 11'(COLS);
    localparam logic [10:0] CELLS    = 11'(COLS * ROWS);
    localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_e;

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [4:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [10:0] waddr_q, waddr_d;

    logic        accept;
    logic        printable;
    logic [4:0]  row_inc;
    logic [10:0] row_base;
    logic [10:0] next_base;
    logic [10:0] cur_addr;

    assign char_ready = (state_q == IDLE);
    assign accept     = char_valid && char_ready;
    assign printable  = (char_data >= 8'h20) && (char_data <= 8'h7E);
    assign row_inc    = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
    assign row_base   = {6'd0, row_q} * COLS_W;
    assign next_base  = {6'd0, row_inc} * COLS_W;
    assign cur_addr   = row_base + {5'd0, col_q};

    // A clear burst issues one write per count, then spends one extra cycle with
    // the count at its terminal value before handing back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (printable) begin
                        we_d    = 1'b1;
                        wdata_d = char_data;
                        waddr_d = cur_addr;
                        if (col_q < LAST_COL) begin
                            col_d = col_q + 6'd1;
                        end else begin
                            col_d   = 6'd0;
                            row_d   = row_inc;
                            cnt_d   = 11'd0;
                            state_d = CLR_ROW;
                        end
                    end else begin
                        case (char_data)
                            8'h0A: begin
                                // LF issues the first clear write on the accept edge
                                col_d   = 6'd0;
                                row_d   = row_inc;
                                we_d    = 1'b1;
                                wdata_d = BLANK;
                                waddr_d = next_base;
                                cnt_d   = 11'd1;
                                state_d = CLR_ROW;
                            end
                            8'h0D: col_d = 6'd0;
                            8'h08: begin
                                if (col_q != 6'd0) begin
                                    col_d   = col_q - 6'd1;
                                    we_d    = 1'b1;
                                    wdata_d = BLANK;
                                    waddr_d = cur_addr - 11'd1;
                                end
                            end
                            8'h0C: begin
                                we_d    = 1'b1;
                                wdata_d = BLANK;
                                waddr_d = 11'd0;
                                cnt_d   = 11'd1;
                                state_d = CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLR_ROW: begin
                if (cnt_q == COLS_W) begin
                    cnt_d   = 11'd0;
                    state_d = IDLE;
                end else begin
                    we_d    = 1'b1;
                    wdata_d = BLANK;
                    waddr_d = row_base + cnt_q;
                    cnt_d   = cnt_q + 11'd1;
                end
            end
            CLR_ALL: begin
                if (cnt_q == CELLS) begin
                    cnt_d   = 11'd0;
                    row_d   = 5'd0;
                    col_d   = 6'd0;
                    state_d = IDLE;
                end else begin
                    we_d    = 1'b1;
                    wdata_d = BLANK;
                    waddr_d = cnt_q;
                    cnt_d   = cnt_q + 11'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset parks in CLR_ALL so the whole screen is blanked after release.
    always_ff @(posedge CLK_CPU or negedge reset) begin
        if (!reset) begin
            state_q <= CLR_ALL;
            cnt_q   <= 11'd0;
            row_q   <= 5'd0;
            col_q   <= 6'd0;
            we_q    <= 1'b0;
            wdata_q <= 8'd0;
            waddr_q <= 11'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
        end
    end

    assign video_write_enable = we_q;
    assign video_write_data   = wdata_q;
    assign video_write_addr   = waddr_q;
    assign cursor_row         = row_q;
    assign cursor_col         = col_q;

endmodule
